// File: rtl/cart_prg_reader.sv
// NES cartridge PRG read sequencer: drives CPU_A/M2/ROMSEL with NES-like read timing and streams bytes out.
// Optional CHECKSUM output (16-bit byte sum) enabled by defining CART_PRG_READER_CHECKSUM_EN.
module cart_prg_reader #(
   parameter int unsigned CLK_DIV = 14
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        START,
   input  logic [14:0] START_ADDR,
   input  logic [15:0] LENGTH,
   input  logic [7:0]  CPU_D,
   output logic [14:0] CPU_A,
   output logic        CPU_RW,
   output logic        M2,
   output logic        ROMSEL,
   output logic [7:0]  OUT_DATA,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        BUSY,
   output logic        DONE
`ifdef CART_PRG_READER_CHECKSUM_EN
   ,
   output logic [15:0] CHECKSUM
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_HOLD} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [14:0] addr_q, addr_d;
   logic [15:0] rem_q, rem_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        m2_q, m2_d;
   logic        romsel_q, romsel_d;
   logic        xfer;

   assign xfer = (state_q == S_HOLD) && OUT_READY;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d = START_ADDR;
               rem_d  = LENGTH;
               div_d  = 8'd0;
               if (LENGTH == 16'd0) done_d  = 1'b1;
               else                 state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (div_q == DIV_LAST) begin
               div_d   = 8'd0;
               state_d = S_ACCESS;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         S_ACCESS: begin
            if (div_q == DIV_LAST) begin
               div_d   = 8'd0;
               data_d  = CPU_D;
               state_d = S_HOLD;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (OUT_READY) begin
               addr_d = addr_q + 15'd1;
               rem_d  = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Bus strobes are registered from the next state so they leave the chip glitch-free.
      m2_d     = (state_d == S_ACCESS);
      romsel_d = ~m2_d;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         div_q    <= 8'd0;
         addr_q   <= 15'd0;
         rem_q    <= 16'd0;
         data_q   <= 8'd0;
         done_q   <= 1'b0;
         m2_q     <= 1'b0;
         romsel_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         data_q   <= data_d;
         done_q   <= done_d;
         m2_q     <= m2_d;
         romsel_q <= romsel_d;
      end
   end

`ifdef CART_PRG_READER_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if ((state_q == S_IDLE) && START) csum_d = 16'd0;
      else if (xfer)                    csum_d = csum_q + {8'h00, data_q};
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) csum_q <= 16'd0;
      else          csum_q <= csum_d;
   end

   assign CHECKSUM = csum_q;
`endif

   assign CPU_A     = addr_q;
   assign CPU_RW    = 1'b1;
   assign M2        = m2_q;
   assign ROMSEL    = romsel_q;
   assign OUT_DATA  = data_q;
   assign OUT_VALID = (state_q == S_HOLD);
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;

endmodule
